tt_um_addon_seq8: RTL and testbench
===================================

TT_UM_ADDON_SEQ8 -- requirements
Module: tt_um_addon_seq8

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, slice width fixed at 2 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  powered indicator; ignored by logic.
REQ-005 ui_in  input  8  operand data bus; written to A or B by load strobes.
REQ-006 uio_in  input  8  controls: [0] load_a, [1] load_b, [2] start, [3] cin; [7:4] ignored.
REQ-007 uo_out  output  8  sum register S[7:0].
REQ-008 uio_out  output  8  [3:0]=0, [4] busy, [5] done, [6] cout, [7] ovf (signed overflow).
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 Internal registers: A[7:0], B[7:0], S[7:0], carry c, slice counter k[1:0], state {IDLE, RUN, DONE}.
REQ-011 Each slice computes {c', S[2k+1:2k]} = A[2k+1:2k] + B[2k+1:2k] + c via 2-bit generate/propagate carry-lookahead (G=A&B, P=A^B, C1=G0|P0&c, c'=G1|P1&C1).
REQ-012 IDLE/DONE: load_a=1 -> A<=ui_in; load_b=1 -> B<=ui_in; both high -> both take ui_in.
REQ-013 IDLE/DONE: start=1 -> state<=RUN, k<=0, c<=cin, S<=0, done<=0, cout<=0, ovf<=0.
REQ-014 Start has priority: load strobes in the same cycle as an accepted start are ignored; the add uses the previously loaded A, B.
REQ-015 RUN: one slice per cycle, k=0..3, S[2k+1:2k] and c updated each edge; k increments.
REQ-016 RUN with k=3: state<=DONE, cout<=c', ovf<=(A[7]==B[7]) && (new S[7]!=A[7]).
REQ-017 RUN: load_a, load_b, start ignored; A, B unchanged.
REQ-018 busy=1 exactly while state=RUN; done=1 exactly while state=DONE.
REQ-019 Latency: start sampled at edge N -> busy from N through N+4, done=1 and S, cout, ovf final after edge N+4.
REQ-020 DONE holds S, cout, ovf, done until the next accepted start; no auto-return to IDLE.
REQ-021 Carry wraps out only through cout; S is modulo 256.
REQ-022 uo_out shows partial sum during RUN (low slices valid, upper slices 0).
REQ-023 No back-to-back overlap: a start in the DONE cycle restarts per REQ-013.

Reset
REQ-024 rst_n=0 asynchronously forces state=IDLE, A=B=S=0, c=0, k=0, busy=done=cout=ovf=0, uo_out=8'h00, uio_out=8'h00.
REQ-025 Reset asserted during RUN aborts the add immediately; after release, block is in IDLE and requires reload/start.
REQ-026 uio_oe=8'hF0 in and out of reset.

Verification
REQ-027 Load A=8'h3C, B=8'h5A, start with cin=0 -> after 4 RUN cycles: S=8'h96, cout=0, ovf=1, done=1.
REQ-028 A=8'hFF, B=8'h01, cin=0 -> S=8'h00, cout=1, ovf=0; A=8'hFF, B=8'h00, cin=1 -> S=8'h00, cout=1, ovf=0.
REQ-029 A=8'h80, B=8'h80, cin=0 -> S=8'h00, cout=1, ovf=1; A=8'h7F, B=8'h00, cin=1 -> S=8'h80, cout=0, ovf=1.
REQ-030 Start held high and load_a with ui_in=8'hAA pulsed during RUN -> result unchanged, busy stays 4 cycles, A unchanged.
REQ-031 load_a=1 and start=1 same cycle with ui_in=8'h10 (A previously 8'h01, B=8'h01) -> S=8'h02.
REQ-032 rst_n low at RUN cycle k=2 -> outputs 0 immediately, state IDLE; fresh load/start then yields correct sum.

Source files
------------

// File: rtl/tt_um_addon_seq8.sv
// tt_um_addon_seq8: 8-bit adder that runs one 2-bit carry-lookahead slice per cycle
//   clk      : clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : power indicator, not used by the logic
//   ui_in    : operand bus, written to A and/or B by the load strobes
//   uio_in   : [0] load_a, [1] load_b, [2] start, [3] cin, [7:4] not used
//   uo_out   : sum register S (partial while busy, low slices first)
//   uio_out  : [4] busy, [5] done, [6] cout, [7] signed overflow, [3:0] zero
//   uio_oe   : constant 8'hF0, the upper uio bits are outputs
module tt_um_addon_seq8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] a, b, s;
    logic [1:0] k;
    logic       c, cout, ovf;
    logic [7:0] a_sh, b_sh;
    logic [1:0] g, p, sum;
    logic       c1, c_nx, accept;

    wire load_a = uio_in[0];
    wire load_b = uio_in[1];
    wire start  = uio_in[2];
    wire cin    = uio_in[3];
    wire unused_in = &{ena, uio_in[7:4], 1'b0};

    // Slice k of each operand is brought down to bits [1:0]
    assign a_sh = a >> {k, 1'b0};
    assign b_sh = b >> {k, 1'b0};
    assign g    = a_sh[1:0] & b_sh[1:0];
    assign p    = a_sh[1:0] ^ b_sh[1:0];
    assign c1   = g[0] | (p[0] & c);
    assign c_nx = g[1] | (p[1] & c1);
    assign sum  = {p[1] ^ c1, p[0] ^ c};

    // A start is honoured only outside RUN and overrides any load in that cycle
    assign accept = start && (state != RUN);

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = RUN;
        else if (state == RUN && k == 2'd3)
            state_nx = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= 8'h00;
            b     <= 8'h00;
            s     <= 8'h00;
            k     <= 2'd0;
            c     <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                k    <= 2'd0;
                c    <= cin;
                s    <= 8'h00;
                cout <= 1'b0;
                ovf  <= 1'b0;
            end else if (state == RUN) begin
                s[{k, 1'b0} +: 2] <= sum;
                c <= c_nx;
                k <= k + 2'd1;
                if (k == 2'd3) begin
                    cout <= c_nx;
                    // sum[1] is the new S[7] on the last slice
                    ovf  <= (a[7] == b[7]) && (sum[1] != a[7]);
                end
            end else begin
                if (load_a) a <= ui_in;
                if (load_b) b <= ui_in;
            end
        end
    end

    assign uo_out  = s;
    assign uio_out = {ovf, cout, state == DONE, state == RUN, 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_addon_seq8.sv
// tb_tt_um_addon_seq8: table-driven check of the sequential slice adder
module tb_tt_um_addon_seq8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_vec = 0;
    int n_err = 0;

    tt_um_addon_seq8 dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk); ui_in = a; uio_in = 8'h01;
        @(negedge clk); ui_in = b; uio_in = 8'h02;
        @(negedge clk); uio_in = 8'h00;
    endtask

    // Waits at negedges for done, returning how many busy samples were seen
    task automatic wait_done(input string name, output int busy_cnt);
        int guard;
        busy_cnt = 0;
        guard = 0;
        while (uio_out[5] !== 1'b1 && guard < 20) begin
            if (uio_out[4] === 1'b1) busy_cnt++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: done never rose", name);
        end
    endtask

    task automatic run(input string name, input logic cin, input logic [7:0] exp_s,
                       input logic exp_cout, input logic exp_ovf);
        int bc;
        uio_in = {4'b0, cin, 3'b100};
        @(negedge clk);
        uio_in = 8'h00;
        wait_done(name, bc);
        chk({name, " busy_cycles"}, 8'(bc), 8'd4);
        chk({name, " S"}, uo_out, exp_s);
        chk({name, " cout"}, {7'b0, uio_out[6]}, {7'b0, exp_cout});
        chk({name, " ovf"}, {7'b0, uio_out[7]}, {7'b0, exp_ovf});
    endtask

    initial begin
        int bc;
        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

        #12;
        chk("reset uo_out", uo_out, 8'h00);
        chk("reset uio_out", uio_out, 8'h00);
        chk("reset uio_oe", uio_oe, 8'hF0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            load(vecs[i].a, vecs[i].b);
            run($sformatf("vec%0d", i), vecs[i].cin, vecs[i].s, vecs[i].cout, vecs[i].ovf);
        end

        // Partial sums appear low slice first while busy
        load(8'h3C, 8'h5A);
        uio_in = 8'h04;
        @(negedge clk); uio_in = 8'h00;
        chk("partial busy", {7'b0, uio_out[4]}, 8'h01);
        chk("partial cleared", uo_out, 8'h00);
        @(negedge clk); chk("partial k0", uo_out, 8'h02);
        @(negedge clk); chk("partial k1", uo_out, 8'h06);
        @(negedge clk); chk("partial k2", uo_out, 8'h16);
        @(negedge clk); chk("partial final", uo_out, 8'h96);
        chk("done flag", {7'b0, uio_out[5]}, 8'h01);
        repeat (3) @(negedge clk);
        chk("done hold S", uo_out, 8'h96);
        chk("done hold flags", uio_out, 8'hA0);

        // Start held and load_a pulsed during RUN must not disturb the add
        uio_in = 8'h04;
        @(negedge clk);
        ui_in = 8'hAA; uio_in = 8'h05;
        @(negedge clk); uio_in = 8'h04;
        @(negedge clk);
        @(negedge clk); uio_in = 8'h00;
        chk("held start busy", {7'b0, uio_out[4]}, 8'h01);
        @(negedge clk);
        chk("held start done", uio_out, 8'hA0);
        chk("held start S", uo_out, 8'h96);
        run("A unchanged", 1'b0, 8'h96, 1'b0, 1'b1);

        // Load in the same cycle as start is dropped
        load(8'h01, 8'h01);
        ui_in = 8'h10; uio_in = 8'h05;
        @(negedge clk); uio_in = 8'h00;
        wait_done("start prio", bc);
        chk("start prio S", uo_out, 8'h02);
        run("start prio rerun", 1'b0, 8'h02, 1'b0, 1'b0);

        // Reset mid-add aborts immediately
        load(8'h3C, 8'h5A);
        uio_in = 8'h04;
        @(negedge clk); uio_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort uo_out", uo_out, 8'h00);
        chk("abort uio_out", uio_out, 8'h00);
        chk("abort uio_oe", uio_oe, 8'hF0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("abort idle", uio_out, 8'h00);
        run("after abort zero ops", 1'b0, 8'h00, 1'b0, 1'b0);
        load(8'h12, 8'h34);
        run("after abort", 1'b1, 8'h47, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
